// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types for the VGA control/status register file:
// response codes, default bus widths and the channel FSM state encodings.
`timescale 1ns/1ps
package vga_axil_pkg;

   localparam int unsigned AXIL_ADDR_W = 32;
   localparam int unsigned AXIL_DATA_W = 32;

   typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
   typedef logic [AXIL_DATA_W-1:0] axil_data_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   typedef enum logic {
      W_COLLECT = 1'b0,
      W_RESP    = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_e;

endpackage

// File: rtl/vga_axil_regfile_decode.sv
// Byte address to register index plus range flag; shared by the write and
// read channels so both agree on which addresses are legal.
`timescale 1ns/1ps
module vga_axil_regfile_decode #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              in_range_o
);

   localparam int unsigned ADDR_LSB = $clog2(DATA_W/8);
   localparam int unsigned LIMIT    = NUM_REGS*DATA_W/8;

   // Low ADDR_LSB bits are dropped: every access is treated as word aligned.
   assign idx_o      = addr_i[ADDR_LSB +: IDX_W];
   assign in_range_o = (addr_i < ADDR_W'(LIMIT));

endmodule

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register file exposing NUM_REGS words in parallel.
// Define VGA_AXIL_REGFILE_WSTRB_EN to honour wstrb; otherwise every write is full word.
`timescale 1ns/1ps
module vga_axil_regfile
   import vga_axil_pkg::*;
#(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       NUM_REGS = 16,
   parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [ADDR_W-1:0]          awaddr,
   input  logic                       awvalid,
   output logic                       awready,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [DATA_W/8-1:0]        wstrb,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [1:0]                 bresp,
   output logic                       bvalid,
   input  logic                       bready,
   input  logic [ADDR_W-1:0]          araddr,
   input  logic                       arvalid,
   output logic                       arready,
   output logic [DATA_W-1:0]          rdata,
   output logic [1:0]                 rresp,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [NUM_REGS*DATA_W-1:0] regs_o,
   output logic [NUM_REGS-1:0]        wr_pulse_o
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned STRB_W = DATA_W/8;

   wr_state_e           wstate_q, wstate_d;
   logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   axil_resp_e          bresp_q, bresp_d;
   logic                commit;
   logic [NUM_REGS-1:0] wr_hit, pulse_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   rd_state_e           rstate_q, rstate_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   axil_resp_e          rresp_q, rresp_d;

   logic [ADDR_W-1:0]   w_addr_eff;
   logic [DATA_W-1:0]   wdata_eff;
   logic [STRB_W-1:0]   wstrb_eff, byte_en;
   logic [IDX_W-1:0]    w_idx, r_idx;
   logic                w_in_range, r_in_range;
   logic                aw_hs, w_hs;

   assign awready = (wstate_q == W_COLLECT) && !aw_got_q;
   assign wready  = (wstate_q == W_COLLECT) && !w_got_q;
   assign bvalid  = (wstate_q == W_RESP);
   assign bresp   = bresp_q;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   // A channel captured on an earlier cycle wins over the live bus value.
   assign w_addr_eff = aw_got_q ? awaddr_q : awaddr;
   assign wdata_eff  = w_got_q  ? wdata_q  : wdata;
   assign wstrb_eff  = w_got_q  ? wstrb_q  : wstrb;

`ifdef VGA_AXIL_REGFILE_WSTRB_EN
   assign byte_en = wstrb_eff;
`else
   logic unused_wstrb;
   assign byte_en      = '1;
   assign unused_wstrb = ^wstrb_eff;
`endif

   vga_axil_regfile_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_wdec (
      .addr_i(w_addr_eff), .idx_o(w_idx), .in_range_o(w_in_range)
   );

   vga_axil_regfile_decode #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rdec (
      .addr_i(araddr), .idx_o(r_idx), .in_range_o(r_in_range)
   );

   always_comb begin
      wstate_d = wstate_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      bresp_d  = bresp_q;
      commit   = 1'b0;
      case (wstate_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               awaddr_d = awaddr;
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = wdata;
               wstrb_d = wstrb;
            end
            if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
               commit   = 1'b1;
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               bresp_d  = w_in_range ? OKAY : SLVERR;
               wstate_d = W_RESP;
            end
         end
         W_RESP: if (bready) wstate_d = W_COLLECT;
         default: wstate_d = W_COLLECT;
      endcase
   end

   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_hit[i] = commit && w_in_range && (w_idx == IDX_W'(i)) && (|byte_en);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wstate_q <= W_COLLECT;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= OKAY;
      end else begin
         wstate_q <= wstate_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         bresp_q  <= bresp_d;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
      end else begin
         pulse_q <= wr_hit;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (byte_en[b]) regs_q[i][8*b +: 8] <= wdata_eff[8*b +: 8];
               end
            end
         end
      end
   end

   // Read samples regs_q before any same-edge commit lands, so it sees the old value.
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         R_IDLE: begin
            if (arvalid) begin
               rdata_d  = r_in_range ? regs_q[r_idx] : '0;
               rresp_d  = r_in_range ? OKAY : SLVERR;
               rstate_d = R_RESP;
            end
         end
         R_RESP: if (rready) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rstate_q <= R_IDLE;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
      end else begin
         rstate_q <= rstate_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   assign arready    = (rstate_q == R_IDLE);
   assign rvalid     = (rstate_q == R_RESP);
   assign rdata      = rdata_q;
   assign rresp      = rresp_q;
   assign wr_pulse_o = pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Scoreboard bench for vga_axil_regfile: directed scenarios plus random traffic
// checked against an array model of the register file.
`timescale 1ns/1ps
module tb_vga_axil_regfile;

   typedef struct {
      logic [1:0]   resp;
      logic [15:0]  pulse;
      logic [511:0] regs;
   } wexp_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } rexp_t;

   logic         clk = 1'b0;
   logic         arst;
   logic [31:0]  awaddr, wdata, araddr, rdata;
   logic [3:0]   wstrb;
   logic         awvalid, awready, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready;
   logic [1:0]   bresp, rresp;
   logic [511:0] regs_o;
   logic [15:0]  wr_pulse_o;

   int           vectors = 0;
   int           miscompares = 0;
   logic [31:0]  model [16];
   wexp_t        wq [$];
   rexp_t        rq [$];
   wexp_t        we;
   rexp_t        re;
   logic         bvalid_prev = 1'b0;

   always #5 clk = ~clk;

   vga_axil_regfile dut (
      .clk(clk), .arst(arst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] flat_model();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = model[i];
      return r;
   endfunction

   // Expected response from the register-file rules: 64-byte window, word index a[5:2].
   task automatic wr_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      wexp_t e;
      int    idx;
      idx     = int'(a[5:2]);
      e.pulse = '0;
      e.resp  = (a < 32'h40) ? 2'b00 : 2'b10;
      if (a < 32'h40) begin
`ifdef VGA_AXIL_REGFILE_WSTRB_EN
         if (s != 4'h0) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            e.pulse = 16'(1) << idx;
         end
`else
         model[idx] = d;
         e.pulse    = 16'(1) << idx;
`endif
      end
      e.regs = flat_model();
      wq.push_back(e);
   endtask

   task automatic rd_push(input logic [31:0] a, output rexp_t e);
      e.resp = (a < 32'h40) ? 2'b00 : 2'b10;
      e.data = (a < 32'h40) ? model[int'(a[5:2])] : 32'h0;
      rq.push_back(e);
   endtask

   task automatic send_aw(input logic [31:0] a);
      bit done = 1'b0;
      awaddr = a; awvalid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk); done = awready;
         @(posedge clk); #1;
      end
      awvalid = 1'b0;
      if (!done) chk("aw_timeout", 0, 1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit done = 1'b0;
      wdata = d; wstrb = s; wvalid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk); done = wready;
         @(posedge clk); #1;
      end
      wvalid = 1'b0;
      if (!done) chk("w_timeout", 0, 1);
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit done = 1'b0;
      araddr = a; arvalid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk); done = arready;
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      if (!done) chk("ar_timeout", 0, 1);
   endtask

   task automatic wait_b();
      for (int n = 0; n < 50 && wq.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      if (wq.size() != 0) begin
         chk("b_timeout", wq.size(), 0);
         wq.delete();
      end
   endtask

   task automatic wait_r();
      for (int n = 0; n < 50 && rq.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      if (rq.size() != 0) begin
         chk("r_timeout", rq.size(), 0);
         rq.delete();
      end
   endtask

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int lead, input int hold);
      logic [1:0] exp_resp;
      wr_push(a, d, s);
      exp_resp = wq[wq.size()-1].resp;
      if (hold > 0) bready = 1'b0;
      if (lead > 0) begin
         fork
            send_w(d, s);
            begin
               repeat (lead) @(posedge clk);
               #1;
               chk("b_early", bvalid, 0);
               chk("wready_after_w", wready, 0);
               send_aw(a);
            end
         join
      end else if (lead < 0) begin
         fork
            send_aw(a);
            begin
               repeat (-lead) @(posedge clk);
               #1;
               chk("b_early", bvalid, 0);
               chk("awready_after_aw", awready, 0);
               send_w(d, s);
            end
         join
      end else begin
         fork
            send_aw(a);
            send_w(d, s);
         join
      end
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, exp_resp);
            chk("awready_hold", awready, 0);
            chk("wready_hold", wready, 0);
         end
         @(posedge clk); #1;
         bready = 1'b1;
      end
      wait_b();
   endtask

   task automatic rd(input logic [31:0] a, input int hold);
      rexp_t e;
      rd_push(a, e);
      if (hold > 0) rready = 1'b0;
      send_ar(a);
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, e.data);
            chk("arready_hold", arready, 0);
         end
         @(posedge clk); #1;
         rready = 1'b1;
      end
      wait_r();
   endtask

   task automatic wr_rd_same(input logic [31:0] a, input logic [31:0] d);
      rexp_t e;
      rd_push(a, e);
      wr_push(a, d, 4'hF);
      fork
         send_aw(a);
         send_w(d, 4'hF);
         send_ar(a);
      join
      wait_b();
      wait_r();
   endtask

   always @(negedge clk) begin
      if (arst) begin
         bvalid_prev = 1'b0;
      end else begin
         if (bvalid && !bvalid_prev) begin
            if (wq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
               chk("wr_pulse", wr_pulse_o, wq[0].pulse);
               chk("regs_o", regs_o, wq[0].regs);
            end
         end else begin
            chk("wr_pulse_idle", wr_pulse_o, 0);
         end
         if (bvalid && bready && wq.size() != 0) begin
            we = wq.pop_front();
            chk("bresp", bresp, we.resp);
         end
         bvalid_prev = bvalid;
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else begin
               re = rq.pop_front();
               chk("rdata", rdata, re.data);
               chk("rresp", rresp, re.resp);
            end
         end
      end
   end

   initial begin
      logic [31:0] a, d;
      arst = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      #50;
      chk("rst_awready", awready, 1);
      chk("rst_wready", wready, 1);
      chk("rst_arready", arready, 1);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_pulse", wr_pulse_o, 0);
      chk("rst_regs", regs_o, 0);
      #50;
      @(posedge clk); #1;
      arst = 1'b0;

      wr(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0);
      rd(32'h8, 0);
      wr(32'h4, 32'h4, 4'hF, 3, 0);
      rd(32'h4, 0);
      wr(32'h10, 32'h0BAD_F00D, 4'hF, -2, 0);
      wr(32'hC, 32'h1357_9BDF, 4'hF, 0, 5);
      rd(32'hC, 5);
      wr(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0);
      rd(32'h40, 0);
      wr(32'h3F, 32'h7777_0001, 4'hF, 0, 0);
      rd(32'h3C, 0);
      wr(32'h0, 32'h1122_3344, 4'hF, 0, 0);
      wr(32'h0, 32'hAABB_CCDD, 4'b0101, 0, 0);
      rd(32'h0, 0);
      wr(32'h0, 32'h5555_5555, 4'b0000, 0, 0);
      rd(32'h0, 0);
      wr_rd_same(32'h14, 32'h600D_CAFE);
      rd(32'h14, 0);

      wr_push(32'h8, 32'h1234_5678, 4'hF);
      bready = 1'b0;
      fork
         send_aw(32'h8);
         send_w(32'h1234_5678, 4'hF);
      join
      chk("b_before_rst", bvalid, 1);
      arst = 1'b1;
      #1;
      chk("rst_mid_bvalid", bvalid, 0);
      chk("rst_mid_regs", regs_o, 0);
      chk("rst_mid_awready", awready, 1);
      wq.delete();
      rq.delete();
      for (int i = 0; i < 16; i++) model[i] = '0;
      @(posedge clk); #1;
      arst = 1'b0;
      bready = 1'b1;
      wr(32'h8, 32'hCAFE_F00D, 4'hF, 0, 0);
      rd(32'h8, 0);

      for (int k = 0; k < 80; k++) begin
         a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) a = $urandom;
         d = $urandom;
         case ($urandom_range(0, 2))
            0: wr(a, d, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
            1: rd(a, int'($urandom_range(0, 2)));
            default: wr_rd_same(a, d);
         endcase
      end
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
